load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared core/memory definitions used by the load/store unit.
//               Provides the datapath width, memory-control width, byte
//               length, the b_h_w size encodings and the LSU FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // Core datapath width (address and data registers).
    localparam int REGISTER_WIDTH = 32;

    // Memory control word is {is_unsign, b_h_w[1:0]}.
    localparam int MEM_CTRL_WIDTH = 3;

    // Bits per addressable byte.
    localparam int BYTE_LENGTH    = 8;

    // b_h_w access-size encodings. Any code other than byte/half is a word.
    localparam logic [1:0] BHW_BYTE = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_WORD = 2'b10;

    // Load/store unit FSM encoding.
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_WAIT   = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_t;

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging the pipeline
//               request/response handshake to memory port B.
//               IDLE   - req_ready high, request captured on req_valid.
//               ACCESS - one-cycle memory strobe (mem_enable).
//               WAIT   - loads only: wait for mem_done or time out.
//               RESP   - response held until resp_ready.
//               Out-of-range requests skip memory and answer with an error.
//               A flush kills the outstanding request; an access already
//               issued to memory still completes but produces no response.
// Ports       :
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_write, req_ctrl, req_addr,
//   req_wdata, req_rd                request fields (req_rd = load dest tag)
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_rd,
//   resp_write, resp_error           response fields
//   flush                            kill any request not yet answered
//   mem_enable, mem_write_en,
//   mem_ctrl, mem_addr, mem_wdata    memory port-B request
//   mem_rdata, mem_done, mem_error   memory port-B response
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // Pipeline request
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [MEM_CTRL_WIDTH-1:0] req_ctrl,
    input  logic [REGISTER_WIDTH-1:0] req_addr,
    input  logic [REGISTER_WIDTH-1:0] req_wdata,
    input  logic [4:0]                req_rd,

    // Pipeline response
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [REGISTER_WIDTH-1:0] resp_rdata,
    output logic [4:0]                resp_rd,
    output logic                      resp_write,
    output logic                      resp_error,

    // Pipeline flush
    input  logic                      flush,

    // Memory port-B request
    output logic                      mem_enable,
    output logic                      mem_write_en,
    output logic [MEM_CTRL_WIDTH-1:0] mem_ctrl,
    output logic [REGISTER_WIDTH-1:0] mem_addr,
    output logic [REGISTER_WIDTH-1:0] mem_wdata,

    // Memory port-B response
    input  logic [REGISTER_WIDTH-1:0] mem_rdata,
    input  logic                      mem_done,
    input  logic                      mem_error
);

    // Counter wide enough to hold TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------------
    // State and registered request fields
    // ------------------------------------------------------------------------
    lsu_state_t                  r_state;
    logic                        r_req_ready;
    logic                        r_kill;
    logic [CNT_W-1:0]            r_wait_cnt;

    logic                        r_write;
    logic [MEM_CTRL_WIDTH-1:0]   r_ctrl;
    logic [REGISTER_WIDTH-1:0]   r_addr;
    logic [REGISTER_WIDTH-1:0]   r_wdata;
    logic [4:0]                  r_rd;

    logic                        r_mem_enable;
    logic                        r_mem_write_en;

    logic                        r_resp_valid;
    logic [REGISTER_WIDTH-1:0]   r_resp_rdata;
    logic [4:0]                  r_resp_rd;
    logic                        r_resp_write;
    logic                        r_resp_error;

    // ------------------------------------------------------------------------
    // Size decode and range check on the incoming request
    // ------------------------------------------------------------------------
    logic [1:0]                  w_size_m1;   // access size minus one
    logic [ADDR_BITS:0]          w_last_byte; // one extra bit catches overflow
    logic                        w_hi_err;
    logic                        w_range_err;
    logic                        w_accept;
    logic                        w_kill;
    logic                        w_timeout;

    always_comb begin
        w_size_m1 = 2'd3;
        case (req_ctrl[1:0])
            BHW_BYTE: w_size_m1 = 2'd0;
            BHW_HALF: w_size_m1 = 2'd1;
            default:  w_size_m1 = 2'd3;
        endcase
    end

    // Highest byte touched; any carry into bit ADDR_BITS means the access
    // runs past the top of memory.
    assign w_last_byte = {1'b0, req_addr[ADDR_BITS-1:0]}
                       + (ADDR_BITS + 1)'(w_size_m1);

    generate
        if (ADDR_BITS < REGISTER_WIDTH) begin : g_hi_chk
            assign w_hi_err = |req_addr[REGISTER_WIDTH-1:ADDR_BITS];
        end else begin : g_no_hi_chk
            assign w_hi_err = 1'b0;
        end
    endgenerate

    assign w_range_err = w_hi_err | w_last_byte[ADDR_BITS];

    // Flush in IDLE blocks acceptance for that cycle.
    assign w_accept  = (r_state == LSU_IDLE) && r_req_ready && req_valid && !flush;

    // Kill takes effect in the same cycle the flush arrives.
    assign w_kill    = r_kill | flush;

    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= LSU_IDLE;
            r_req_ready    <= 1'b0;
            r_kill         <= 1'b0;
            r_wait_cnt     <= '0;
            r_write        <= 1'b0;
            r_ctrl         <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rd           <= '0;
            r_mem_enable   <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_rd      <= '0;
            r_resp_write   <= 1'b0;
            r_resp_error   <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_ctrl      <= req_ctrl;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_rd        <= req_rd;
                        r_kill      <= 1'b0;
                        r_req_ready <= 1'b0;
                        if (w_range_err) begin
                            // Answer immediately; memory is never strobed.
                            r_state      <= LSU_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_rd    <= req_rd;
                            r_resp_write <= req_write;
                        end else begin
                            r_state        <= LSU_ACCESS;
                            r_mem_enable   <= 1'b1;
                            r_mem_write_en <= req_write;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                LSU_ACCESS: begin
                    r_mem_enable   <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    if (r_write) begin
                        // Stores complete in the strobe cycle.
                        if (w_kill) begin
                            r_state     <= LSU_IDLE;
                            r_req_ready <= 1'b1;
                            r_kill      <= 1'b0;
                        end else begin
                            r_state      <= LSU_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b0;
                            r_resp_rdata <= '0;
                            r_resp_rd    <= r_rd;
                            r_resp_write <= 1'b1;
                        end
                    end else begin
                        r_state    <= LSU_WAIT;
                        r_wait_cnt <= '0;
                        r_kill     <= w_kill;
                    end
                end

                LSU_WAIT: begin
                    r_kill <= w_kill;
                    if (mem_done || w_timeout) begin
                        r_wait_cnt <= '0;
                        if (w_kill) begin
                            r_state     <= LSU_IDLE;
                            r_req_ready <= 1'b1;
                            r_kill      <= 1'b0;
                        end else begin
                            r_state      <= LSU_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rd    <= r_rd;
                            r_resp_write <= 1'b0;
                            if (mem_done) begin
                                r_resp_rdata <= mem_rdata;
                                r_resp_error <= mem_error;
                            end else begin
                                r_resp_rdata <= '0;
                                r_resp_error <= 1'b1;
                            end
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end

                LSU_RESP: begin
                    // A flush drops the response just like a handshake would.
                    if (flush || resp_ready) begin
                        r_state      <= LSU_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_kill       <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= LSU_IDLE;
                    r_req_ready    <= 1'b1;
                    r_mem_enable   <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_resp_valid   <= 1'b0;
                    r_kill         <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready    = r_req_ready;

    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_rd      = r_resp_rd;
    assign resp_write   = r_resp_write;
    assign resp_error   = r_resp_error;

    // ctrl/addr/wdata come straight from the captured request, so they stay
    // held through WAIT without extra storage.
    assign mem_enable   = r_mem_enable;
    assign mem_write_en = r_mem_write_en;
    assign mem_ctrl     = r_ctrl;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A table of request
//               vectors is applied in a loop with a small memory responder;
//               expected responses travel through a scoreboard queue. Flush,
//               timeout, back-pressure and reset corner cases follow as
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [MEM_CTRL_WIDTH-1:0] req_ctrl;
    logic [REGISTER_WIDTH-1:0] req_addr;
    logic [REGISTER_WIDTH-1:0] req_wdata;
    logic [4:0]                req_rd;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [REGISTER_WIDTH-1:0] resp_rdata;
    logic [4:0]                resp_rd;
    logic                      resp_write;
    logic                      resp_error;
    logic                      flush;
    logic                      mem_enable;
    logic                      mem_write_en;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl;
    logic [REGISTER_WIDTH-1:0] mem_addr;
    logic [REGISTER_WIDTH-1:0] mem_wdata;
    logic [REGISTER_WIDTH-1:0] mem_rdata;
    logic                      mem_done;
    logic                      mem_error;

    load_store_unit #(.ADDR_BITS(8), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_ctrl     (req_ctrl),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_write   (resp_write),
        .resp_error   (resp_error),
        .flush        (flush),
        .mem_enable   (mem_enable),
        .mem_write_en (mem_write_en),
        .mem_ctrl     (mem_ctrl),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .mem_error    (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // delay: cycles from the strobe until mem_done (0 = never answer)
    // exp_lat: cycle of first resp_valid counted from the accept cycle
    typedef struct {
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] mdata;
        logic        merr;
        int          hold;
        logic        exp_mem;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        write;
        logic        error;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!req_ready) chk("ready_wait_expired", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        int          cyc;
        int          pulses;
        int          countdown;
        logic        seen;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [2:0]  s_ctrl;
        logic        s_we;
        string       tag;
        tag       = $sformatf("v%0d", idx);
        s_addr    = '0;
        s_wdata   = '0;
        s_ctrl    = '0;
        s_we      = 1'b0;
        resp_ready = (v.hold == 0);
        e.rdata = v.exp_rdata;
        e.rd    = v.rd;
        e.write = v.wr;
        e.error = v.exp_err;
        sb.push_back(e);
        issue(v.wr, v.ctrl, v.addr, v.wdata, v.rd);
        cyc       = 1;
        pulses    = 0;
        countdown = 0;
        seen      = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                if (mem_enable) begin
                    pulses++;
                    s_addr  = mem_addr;
                    s_wdata = mem_wdata;
                    s_ctrl  = mem_ctrl;
                    s_we    = mem_write_en;
                    if (!mem_write_en && v.delay > 0) countdown = v.delay;
                end
                @(posedge clk); #1;
                cyc++;
                mem_done  = 1'b0;
                mem_error = 1'b0;
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        mem_done  = 1'b1;
                        mem_rdata = v.mdata;
                        mem_error = v.merr;
                    end
                end
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, "_resp_wait_expired"}, 32'(seen), 32'd1);
            resp_ready = 1'b1;
            return;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({tag, "_mem_pulses"}, 32'(pulses), v.exp_mem ? 32'd1 : 32'd0);
        if (v.exp_mem) begin
            chk({tag, "_mem_addr"}, s_addr, v.addr);
            chk({tag, "_mem_ctrl"}, 32'(s_ctrl), 32'(v.ctrl));
            chk({tag, "_mem_we"}, 32'(s_we), 32'(v.wr));
            if (v.wr) chk({tag, "_mem_wdata"}, s_wdata, v.wdata);
        end
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_rd"}, 32'(resp_rd), 32'(e.rd));
        chk({tag, "_write"}, 32'(resp_write), 32'(e.write));
        chk({tag, "_error"}, 32'(resp_error), 32'(e.error));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_hold_error"}, 32'(resp_error), 32'(e.error));
            chk({tag, "_hold_rd"}, 32'(resp_rd), 32'(e.rd));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_ctrl   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rd     = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        mem_rdata  = '0;
        mem_done   = 1'b0;
        mem_error  = 1'b0;

        //              wr   ctrl    addr      wdata         rd  dly mdata         me  hld mem  err  rdata         lat
        vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        5'd1, 1, 32'hDEADBEEF, 1'b0, 0, 1'b1, 1'b0, 32'hDEADBEEF, 3});
        vecs.push_back('{1'b1, 3'b000, 32'h23,  32'hAB,       5'd2, 0, 32'h0,        1'b0, 0, 1'b1, 1'b0, 32'h0,        2});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        5'd3, 1, 32'h0,        1'b0, 0, 1'b0, 1'b1, 32'h0,        1});
        vecs.push_back('{1'b0, 3'b010, 32'hFE,  32'h0,        5'd4, 1, 32'h0,        1'b0, 0, 1'b0, 1'b1, 32'h0,        1});
        vecs.push_back('{1'b0, 3'b010, 32'hFC,  32'h0,        5'd5, 1, 32'h12345678, 1'b0, 0, 1'b1, 1'b0, 32'h12345678, 3});
        vecs.push_back('{1'b0, 3'b001, 32'hFF,  32'h0,        5'd6, 1, 32'h0,        1'b0, 0, 1'b0, 1'b1, 32'h0,        1});
        vecs.push_back('{1'b0, 3'b100, 32'hFF,  32'h0,        5'd7, 3, 32'h000000A5, 1'b0, 0, 1'b1, 1'b0, 32'h000000A5, 5});
        vecs.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        5'd8, 2, 32'h00000055, 1'b1, 0, 1'b1, 1'b1, 32'h00000055, 4});
        vecs.push_back('{1'b1, 3'b010, 32'hFC,  32'hCAFEF00D, 5'd9, 0, 32'h0,        1'b0, 0, 1'b1, 1'b0, 32'h0,        2});
        vecs.push_back('{1'b1, 3'b001, 32'hFF,  32'h1234,     5'd10,0, 32'h0,        1'b0, 0, 1'b0, 1'b1, 32'h0,        1});
        vecs.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        5'd11,0, 32'h0,        1'b0, 0, 1'b1, 1'b1, 32'h0,        17});
        vecs.push_back('{1'b0, 3'b010, 32'h80,  32'h0,        5'd12,1, 32'h0BADF00D, 1'b0, 5, 1'b1, 1'b0, 32'h0BADF00D, 3});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",    32'(req_ready),    32'd0);
        chk("rst_resp_valid",   32'(resp_valid),   32'd0);
        chk("rst_mem_enable",   32'(mem_enable),   32'd0);
        chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        chk("rst_resp_error",   32'(resp_error),   32'd0);
        chk("rst_resp_rdata",   resp_rdata,        32'd0);
        chk("rst_resp_rd",      32'(resp_rd),      32'd0);
        chk("rst_mem_addr",     mem_addr,          32'd0);
        chk("rst_mem_wdata",    mem_wdata,         32'd0);
        chk("rst_mem_ctrl",     32'(mem_ctrl),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Stray mem_done after the timeout is ignored
        mem_done  = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_done  = 1'b0;
        @(negedge clk);
        chk("stray_done_valid", 32'(resp_valid), 32'd0);
        chk("stray_done_ready", 32'(req_ready),  32'd1);

        // Flush in IDLE suppresses acceptance
        req_valid = 1'b1; req_write = 1'b0; req_ctrl = 3'b010; req_addr = 32'h10; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("fi_ready",      32'(req_ready),  32'd1);
        chk("fi_mem_enable", 32'(mem_enable), 32'd0);

        // Flush in WAIT: load completes in memory, no response
        issue(1'b0, 3'b010, 32'h30, 32'h0, 5'd13);
        @(negedge clk);
        chk("fw_access_en", 32'(mem_enable), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fw_wait_en",   32'(mem_enable), 32'd0);
        chk("fw_addr_hold", mem_addr,        32'h30);
        chk("fw_ctrl_hold", 32'(mem_ctrl),   32'(3'b010));
        @(posedge clk); #1;
        flush = 1'b0; mem_done = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("fw_valid_done", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        mem_done = 1'b0;
        @(negedge clk);
        chk("fw_idle_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("fw_no_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end

        // Flush in ACCESS on a store: the write still goes out
        issue(1'b1, 3'b010, 32'h50, 32'h77, 5'd14);
        flush = 1'b1;
        @(negedge clk);
        chk("fa_mem_enable", 32'(mem_enable),   32'd1);
        chk("fa_mem_we",     32'(mem_write_en), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fa_valid", 32'(resp_valid), 32'd0);
        chk("fa_ready", 32'(req_ready),  32'd1);

        // Flush in RESP drops the response
        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd15);
        @(negedge clk);
        chk("fr_valid", 32'(resp_valid), 32'd1);
        chk("fr_error", 32'(resp_error), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fr_dropped", 32'(resp_valid), 32'd0);
        chk("fr_ready",   32'(req_ready),  32'd1);
        resp_ready = 1'b1;

        // Reset asserted during ACCESS drops the strobe immediately
        issue(1'b1, 3'b010, 32'h60, 32'h5, 5'd16);
        #2;
        chk("ra_pre_enable", 32'(mem_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_mem_enable", 32'(mem_enable),   32'd0);
        chk("ra_mem_we",     32'(mem_write_en), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset mid-WAIT
        issue(1'b0, 3'b010, 32'h64, 32'h0, 5'd17);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rw_mem_enable", 32'(mem_enable), 32'd0);
        chk("rw_resp_valid", 32'(resp_valid), 32'd0);
        chk("rw_req_ready",  32'(req_ready),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rw_ready_after_edge", 32'(req_ready), 32'd1);

        // Normal operation resumes after reset
        run_vec(vecs[0], 100);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
